// File: rtl/synth_reg_vdelay.sv
// synth_reg_vdelay: runtime-selectable delay line for a CHANNELS x WIDTH
// sample bus and its valid flag. Delay is 0..MAX_LATENCY ce-cycles.
// A latency change flushes the pipe so that no stale or mixed-age sample
// is ever presented as valid.
module synth_reg_vdelay #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 1,
  parameter int MAX_LATENCY = 32,
  localparam int LAT_W      = $clog2(MAX_LATENCY + 1),
  localparam int BUS_W      = WIDTH * CHANNELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ce,
  input  logic [LAT_W-1:0] latency,
  input  logic             i_valid,
  input  logic [BUS_W-1:0] i,
  output logic             o_valid,
  output logic [BUS_W-1:0] o,
  output logic             o_busy
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);

  // Shift banks: d[k]/v[k] hold the sample accepted k ce-edges ago.
  logic [BUS_W-1:0]     d [1:MAX_LATENCY];
  logic [MAX_LATENCY:1] v;

  state_t           state;
  state_t           state_next;
  logic [LAT_W-1:0] lat_q;
  logic [LAT_W-1:0] lat_next;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_next;
  logic [LAT_W-1:0] lat_clamp;
  logic             lat_change;
  logic             raw_valid;

  // Requested latency saturated to the deepest tap.
  assign lat_clamp  = (latency > LAT_MAX) ? LAT_MAX : latency;
  assign lat_change = (lat_clamp != lat_q);

  // Shift the data/valid banks on ce; clear on rst or clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= MAX_LATENCY; k++) begin
        d[k] <= '0;
      end
      v <= '0;
    end else if (clr) begin
      for (int k = 1; k <= MAX_LATENCY; k++) begin
        d[k] <= '0;
      end
      v <= '0;
    end else if (ce) begin
      d[1] <= i;
      v[1] <= i_valid;
      for (int k = 2; k <= MAX_LATENCY; k++) begin
        d[k] <= d[k-1];
        v[k] <= v[k-1];
      end
    end else begin
      for (int k = 1; k <= MAX_LATENCY; k++) begin
        d[k] <= d[k];
      end
      v <= v;
    end
  end

  // FSM state, active latency and flush counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      lat_q <= LAT_ZERO;
      cnt   <= LAT_ZERO;
    end else begin
      state <= state_next;
      lat_q <= lat_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: clr beats a latency change, which beats flush counting.
  always_comb begin
    state_next = state;
    lat_next   = lat_q;
    cnt_next   = cnt;
    if (clr) begin
      // Banks are emptied on the same edge, so no flush is needed.
      state_next = RUN;
      lat_next   = lat_clamp;
      cnt_next   = LAT_ZERO;
    end else if (lat_change) begin
      // Counting starts on the following ce edge, even if ce is high now.
      state_next = FLUSH;
      lat_next   = lat_clamp;
      cnt_next   = lat_clamp;
    end else begin
      case (state)
        RUN: begin
          state_next = RUN;
        end
        FLUSH: begin
          if (cnt == LAT_ZERO) begin
            state_next = RUN;
          end else if (ce) begin
            cnt_next = cnt - LAT_ONE;
            if (cnt == LAT_ONE) begin
              state_next = RUN;
            end else begin
              state_next = FLUSH;
            end
          end else begin
            state_next = FLUSH;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = LAT_ZERO;
        end
      endcase
    end
  end

  // Output tap select: latency 0 bypasses the bank entirely.
  always_comb begin
    o         = i;
    raw_valid = i_valid;
    if (lat_q != LAT_ZERO) begin
      o         = '0;
      raw_valid = 1'b0;
      for (int k = 1; k <= MAX_LATENCY; k++) begin
        if (lat_q == LAT_W'(k)) begin
          o         = d[k];
          raw_valid = v[k];
        end
      end
    end else begin
      o         = i;
      raw_valid = i_valid;
    end
  end

  assign o_valid = raw_valid && (state == RUN);
  assign o_busy  = (state == FLUSH);

endmodule

// File: tb/tb_synth_reg_vdelay.sv
// Self-checking bench for synth_reg_vdelay: directed scenarios plus a
// randomized stream, all compared against a history-queue reference model.
module tb_synth_reg_vdelay;

  localparam int W   = 16;
  localparam int CH  = 1;
  localparam int ML  = 32;
  localparam int LW  = $clog2(ML + 1);
  localparam int BW  = W * CH;

  localparam int W1  = 12;
  localparam int CH1 = 4;
  localparam int BW1 = W1 * CH1;

  logic          clk = 1'b0;
  logic          rst, clr, ce, i_valid;
  logic [LW-1:0] latency;
  logic [BW-1:0] i;
  logic          o_valid, o_busy;
  logic [BW-1:0] o;

  logic           rst1, clr1, ce1, i_valid1;
  logic [LW-1:0]  latency1;
  logic [BW1-1:0] i1;
  logic           o_valid1, o_busy1;
  logic [BW1-1:0] o1;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of accepted samples, newest first ({valid,data}).
  logic [BW:0] hist[$];
  int          mlat;
  int          flush_left;
  bit          mbusy;

  always #5 clk = ~clk;

  synth_reg_vdelay #(.WIDTH(W), .CHANNELS(CH), .MAX_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ce(ce), .latency(latency),
    .i_valid(i_valid), .i(i), .o_valid(o_valid), .o(o), .o_busy(o_busy)
  );

  synth_reg_vdelay #(.WIDTH(W1), .CHANNELS(CH1), .MAX_LATENCY(ML)) dut4 (
    .clk(clk), .rst(rst1), .clr(clr1), .ce(ce1), .latency(latency1),
    .i_valid(i_valid1), .i(i1), .o_valid(o_valid1), .o(o1), .o_busy(o_busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample accepted 'age' ce-edges ago; empty slots read as zero.
  function automatic logic [BW:0] aged(input int age);
    if (age >= 1 && age <= hist.size()) return hist[age-1];
    return '0;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    int lc;
    lc = (int'(latency) > ML) ? ML : int'(latency);
    if (clr) begin
      hist.delete();
      mlat  = lc;
      mbusy = 1'b0;
      flush_left = 0;
    end else begin
      if (ce) begin
        hist.push_front({i_valid, i});
        if (hist.size() > ML) void'(hist.pop_back());
      end
      if (lc != mlat) begin
        mlat = lc;
        mbusy = 1'b1;
        flush_left = lc;
      end else if (mbusy) begin
        if (flush_left == 0) mbusy = 1'b0;
        else if (ce) begin
          flush_left--;
          if (flush_left == 0) mbusy = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [BW:0] e;
    e = (mlat == 0) ? {i_valid, i} : aged(mlat);
    check({tag, ".o"}, 64'(o), 64'(e[BW-1:0]));
    check({tag, ".o_valid"}, 64'(o_valid), 64'(e[BW] && !mbusy));
    check({tag, ".o_busy"}, 64'(o_busy), 64'(mbusy));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1; clr = 1'b0; ce = 1'b0; latency = '0; i_valid = 1'b0; i = '0;
    rst1 = 1'b1; clr1 = 1'b0; ce1 = 1'b1; latency1 = '0; i_valid1 = 1'b0; i1 = '0;
    hist.delete(); mlat = 0; mbusy = 1'b0; flush_left = 0;
    #1;
    check("reset.o", 64'(o), 64'(0));
    check("reset.o_valid", 64'(o_valid), 64'(0));
    check("reset.o_busy", 64'(o_busy), 64'(0));
    step1(); step1();
    rst = 1'b0;

    // 1: latency 5, ce constant -> five busy cycles, then ramp data.
    latency = LW'(5); ce = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      step("t1flush");
      if (o_busy) busy_cnt++;
    end
    check("t1.busy_cycles", 64'(busy_cnt), 64'(5));
    for (int n = 1; n <= 10; n++) begin
      i = BW'(n); i_valid = 1'b1;
      step("t1data");
    end
    i_valid = 1'b0; i = '0;
    for (int n = 0; n < 8; n++) step("t1drain");

    // 2: zero latency passthrough, then switch to 3.
    latency = LW'(0);
    for (int n = 0; n < 6; n++) begin
      i = BW'($urandom); i_valid = 1'($urandom);
      step("t2zero");
    end
    latency = LW'(3);
    for (int n = 0; n < 8; n++) begin
      i = BW'($urandom); i_valid = 1'b1;
      step("t2lat3");
    end

    // 3: latency 4 with ce toggling.
    latency = LW'(4); i_valid = 1'b0; i = '0;
    for (int n = 0; n < 6; n++) step("t3flush");
    i = BW'(16'hBEEF); i_valid = 1'b1; ce = 1'b1;
    step("t3load");
    i = '0; i_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      ce = (n % 2 == 1);
      step("t3toggle");
    end
    ce = 1'b1;

    // 4: over-range latency clamps to the deepest tap.
    latency = LW'(ML + 7);
    for (int n = 0; n < ML + 2; n++) step("t4flush");
    i = BW'(16'hA5C3); i_valid = 1'b1;
    step("t4load");
    i = '0; i_valid = 1'b0;
    for (int n = 0; n < ML + 2; n++) step("t4drain");

    // 5: clr mid-stream with ce high.
    latency = LW'(6);
    for (int n = 0; n < 20; n++) begin
      i = BW'($urandom); i_valid = 1'b1;
      step("t5fill");
    end
    clr = 1'b1;
    step("t5clr");
    check("t5.o_after_clr", 64'(o), 64'(0));
    clr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      i = BW'($urandom); i_valid = 1'($urandom);
      step("t5after");
    end

    // Randomized stream with occasional latency changes and clears.
    for (int n = 0; n < 400; n++) begin
      ce = ($urandom_range(3, 0) != 0);
      i = BW'($urandom);
      i_valid = 1'($urandom);
      clr = ($urandom_range(59, 0) == 0);
      if ($urandom_range(29, 0) == 0) latency = LW'($urandom_range(ML + 10, 0));
      step("rand");
    end
    clr = 1'b0;

    // 6: four channels of 12 bits, latency 2, then async reset mid-flush.
    latency1 = LW'(2);
    #1;
    check("t6.reset_o", 64'(o1), 64'(0));
    check("t6.reset_busy", 64'(o_busy1), 64'(0));
    rst1 = 1'b0;
    step1();
    check("t6.flush_busy", 64'(o_busy1), 64'(1));
    step1(); step1();
    check("t6.run_busy", 64'(o_busy1), 64'(0));
    i1 = {12'h444, 12'h333, 12'h222, 12'h111}; i_valid1 = 1'b1;
    step1();
    i1 = '0; i_valid1 = 1'b0;
    #1;
    check("t6.not_yet_valid", 64'(o_valid1), 64'(0));
    step1();
    check("t6.o_channels", 64'(o1), 64'({12'h444, 12'h333, 12'h222, 12'h111}));
    check("t6.o_valid", 64'(o_valid1), 64'(1));
    latency1 = LW'(5);
    step1();
    check("t6.midflush_busy", 64'(o_busy1), 64'(1));
    #2;
    rst1 = 1'b1;
    #1;
    check("t6.async_o", 64'(o1), 64'(0));
    check("t6.async_valid", 64'(o_valid1), 64'(0));
    check("t6.async_busy", 64'(o_busy1), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
